sram_like_arbiter: RTL and testbench

- Shares one downstream SRAM-like port between the instruction-fetch requester (port 0, "inst") and the load/store requester (port 1, "data").
- Arbitrates request issue and holds the winning request stable until the downstream accepts its address.
- Records the owner of every accepted transaction in an in-order FIFO and steers each data_ok/rdata back to that owner.
- Sits between the pipeline's inst/data SRAM-like interfaces and the bus bridge.

---
 rtl/sram_like_arbiter_pkg.sv | 15 +
 rtl/arb_owner_fifo.sv | 67 ++++++
 rtl/sram_like_arbiter.sv | 173 +++++++++++++++++
 tb/tb_sram_like_arbiter.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/sram_like_arbiter_pkg.sv
// rtl/sram_like_arbiter_pkg.sv - shared owner IDs, size encodings and depth default for the SRAM-like arbiter
package sram_like_arbiter_pkg;

  localparam int OT_DEPTH_DEF = 4;

  localparam logic OWNER_INST = 1'b0;
  localparam logic OWNER_DATA = 1'b1;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2
  } sram_size_e;

endpackage

// File: rtl/arb_owner_fifo.sv
// rtl/arb_owner_fifo.sv - in-order 1-bit owner FIFO recording who owns each accepted transaction
module arb_owner_fifo
  import sram_like_arbiter_pkg::*;
#(
  parameter int OT_DEPTH = OT_DEPTH_DEF,
  parameter int OT_AW    = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             push_owner,
  input  logic             pop,
  output logic [OT_AW:0]   count,
  output logic             full,
  output logic             empty,
  output logic             head
);

  logic [OT_DEPTH-1:0] mem_q, mem_d;
  logic [OT_AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [OT_AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [OT_AW:0]      count_q, count_d;
  logic                do_push, do_pop;

  assign full  = (count_q == (OT_AW+1)'(OT_DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointers are OT_AW bits wide, so increment wraps modulo the power-of-2 depth.
  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_owner;
      wr_ptr_d        = wr_ptr_q + (OT_AW)'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + (OT_AW)'(1);
    end
    if (do_push && !do_pop) begin
      count_d = count_q + (OT_AW+1)'(1);
    end else if (!do_push && do_pop) begin
      count_d = count_q - (OT_AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q    <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/sram_like_arbiter.sv
// rtl/sram_like_arbiter.sv - shares one SRAM-like port between inst and data requesters; ARB_RR_EN selects round-robin
module sram_like_arbiter
  import sram_like_arbiter_pkg::*;
#(
  parameter int OT_DEPTH = OT_DEPTH_DEF,
  parameter int OT_AW    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        m_req,
  output logic        m_wr,
  output logic [1:0]  m_size,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic        m_addr_ok,
  input  logic        m_data_ok,
  input  logic [31:0] m_rdata,
  output logic        data_busy,
  output logic        proto_err
);

  logic           lock_valid_q, lock_valid_d;
  logic           lock_owner_q, lock_owner_d;
  logic [OT_AW:0] data_out_q, data_out_d;
  logic           proto_err_q, proto_err_d;
`ifdef ARB_RR_EN
  logic           last_winner_q, last_winner_d;
`endif

  logic           grant_valid, grant_owner, grant_req;
  logic           accept, pop, push_data, pop_data;
  logic [OT_AW:0] fifo_count;
  logic           fifo_full, fifo_empty, fifo_head;

  always_comb begin
    grant_valid = 1'b0;
    grant_owner = OWNER_INST;
    if (lock_valid_q) begin
      grant_valid = 1'b1;
      grant_owner = lock_owner_q;
    end else if (data_req && inst_req) begin
      grant_valid = 1'b1;
`ifdef ARB_RR_EN
      grant_owner = ~last_winner_q;
`else
      grant_owner = OWNER_DATA;
`endif
    end else if (data_req) begin
      grant_valid = 1'b1;
      grant_owner = OWNER_DATA;
    end else if (inst_req) begin
      grant_valid = 1'b1;
      grant_owner = OWNER_INST;
    end
  end

  assign grant_req = grant_valid && ((grant_owner == OWNER_DATA) ? data_req : inst_req);
  // No full-cycle bypass: a pop in the same cycle does not reopen issue.
  assign m_req     = grant_req && !fifo_full;

  always_comb begin
    m_wr    = 1'b0;
    m_size  = 2'b00;
    m_addr  = 32'h0;
    m_wdata = 32'h0;
    if (grant_valid) begin
      if (grant_owner == OWNER_DATA) begin
        m_wr    = data_wr;
        m_size  = data_size;
        m_addr  = data_addr;
        m_wdata = data_wdata;
      end else begin
        m_wr    = inst_wr;
        m_size  = inst_size;
        m_addr  = inst_addr;
        m_wdata = inst_wdata;
      end
    end
  end

  assign accept       = m_req && m_addr_ok;
  assign inst_addr_ok = accept && (grant_owner == OWNER_INST);
  assign data_addr_ok = accept && (grant_owner == OWNER_DATA);

  assign pop          = m_data_ok && !fifo_empty;
  assign inst_data_ok = pop && (fifo_head == OWNER_INST);
  assign data_data_ok = pop && (fifo_head == OWNER_DATA);
  assign inst_rdata   = inst_data_ok ? m_rdata : 32'h0;
  assign data_rdata   = data_data_ok ? m_rdata : 32'h0;

  assign push_data = data_addr_ok;
  assign pop_data  = data_data_ok;

  always_comb begin
    lock_valid_d = lock_valid_q;
    lock_owner_d = lock_owner_q;
    if (accept) begin
      lock_valid_d = 1'b0;
    end else if (m_req) begin
      lock_valid_d = 1'b1;
      lock_owner_d = grant_owner;
    end else if (lock_valid_q && !grant_req) begin
      lock_valid_d = 1'b0;
    end

    data_out_d = data_out_q;
    if (push_data && !pop_data) begin
      data_out_d = data_out_q + (OT_AW+1)'(1);
    end else if (!push_data && pop_data) begin
      data_out_d = data_out_q - (OT_AW+1)'(1);
    end

    proto_err_d = proto_err_q || (m_data_ok && fifo_empty);
`ifdef ARB_RR_EN
    last_winner_d = accept ? grant_owner : last_winner_q;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lock_valid_q  <= 1'b0;
      lock_owner_q  <= OWNER_INST;
      data_out_q    <= '0;
      proto_err_q   <= 1'b0;
`ifdef ARB_RR_EN
      last_winner_q <= OWNER_DATA;
`endif
    end else begin
      lock_valid_q  <= lock_valid_d;
      lock_owner_q  <= lock_owner_d;
      data_out_q    <= data_out_d;
      proto_err_q   <= proto_err_d;
`ifdef ARB_RR_EN
      last_winner_q <= last_winner_d;
`endif
    end
  end

  assign data_busy = (lock_valid_q && (lock_owner_q == OWNER_DATA)) || (data_out_q != '0);
  assign proto_err = proto_err_q;

  arb_owner_fifo #(
    .OT_DEPTH (OT_DEPTH),
    .OT_AW    (OT_AW)
  ) u_owner_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (accept),
    .push_owner (grant_owner),
    .pop        (pop),
    .count      (fifo_count),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .head       (fifo_head)
  );

endmodule

// File: tb/tb_sram_like_arbiter.sv
// tb/tb_sram_like_arbiter.sv - table-driven self-checking bench for sram_like_arbiter
module tb_sram_like_arbiter;

`ifdef ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk, reset;
  logic        inst_req, inst_wr, data_req, data_wr;
  logic [1:0]  inst_size, data_size, m_size;
  logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata;
  logic        m_req, m_wr, m_addr_ok, m_data_ok, data_busy, proto_err;
  logic [31:0] m_addr, m_wdata, m_rdata;

  int checks = 0;
  int errors = 0;

  sram_like_arbiter dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
    .inst_wdata(inst_wdata), .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
    .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .data_rdata(data_rdata),
    .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata),
    .data_busy(data_busy), .proto_err(proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit        ir;
    bit [31:0] ia;
    bit        dr;
    bit [31:0] da;
    bit        aok;
    bit        dok;
    bit [31:0] rd;
    bit        e_mreq;
    bit [31:0] e_maddr;
    bit        e_mwr;
    bit        e_iaok;
    bit        e_daok;
    bit        e_idok;
    bit        e_ddok;
    bit        e_busy;
    bit        e_perr;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit ir, bit [31:0] ia, bit dr, bit [31:0] da, bit aok, bit dok,
                              bit [31:0] rd, bit mreq, bit [31:0] maddr, bit mwr, bit iaok,
                              bit daok, bit idok, bit ddok, bit busy, bit perr);
    vec_t v;
    v.ir = ir; v.ia = ia; v.dr = dr; v.da = da; v.aok = aok; v.dok = dok; v.rd = rd;
    v.e_mreq = mreq; v.e_maddr = maddr; v.e_mwr = mwr; v.e_iaok = iaok; v.e_daok = daok;
    v.e_idok = idok; v.e_ddok = ddok; v.e_busy = busy; v.e_perr = perr;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    inst_req  = v.ir; inst_addr = v.ia;
    data_req  = v.dr; data_addr = v.da;
    m_addr_ok = v.aok; m_data_ok = v.dok; m_rdata = v.rd;
  endtask

  task automatic step(input string tag, input vec_t v);
    drive(v);
    @(negedge clk);
    chk({tag, " m_req"}, 32'(m_req), 32'(v.e_mreq));
    chk({tag, " m_addr"}, m_addr, v.e_maddr);
    chk({tag, " m_wr"}, 32'(m_wr), 32'(v.e_mwr));
    chk({tag, " inst_addr_ok"}, 32'(inst_addr_ok), 32'(v.e_iaok));
    chk({tag, " data_addr_ok"}, 32'(data_addr_ok), 32'(v.e_daok));
    chk({tag, " inst_data_ok"}, 32'(inst_data_ok), 32'(v.e_idok));
    chk({tag, " data_data_ok"}, 32'(data_data_ok), 32'(v.e_ddok));
    chk({tag, " inst_rdata"}, inst_rdata, v.e_idok ? v.rd : 32'h0);
    chk({tag, " data_rdata"}, data_rdata, v.e_ddok ? v.rd : 32'h0);
    chk({tag, " data_busy"}, 32'(data_busy), 32'(v.e_busy));
    chk({tag, " proto_err"}, 32'(proto_err), 32'(v.e_perr));
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  vec_t idle;

  initial begin
    inst_wr = 1'b0; inst_size = 2'd2; inst_wdata = 32'h1111_1111;
    data_wr = 1'b1; data_size = 2'd1; data_wdata = 32'hd0d0_d0d0;
    idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(idle);
    reset = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst m_req", 32'(m_req), 0);
    chk("rst data_busy", 32'(data_busy), 0);
    chk("rst proto_err", 32'(proto_err), 0);
    @(posedge clk); #1;
    reset = 1'b0;

    // priority / round-robin on a tie, then drain
    tbl.push_back(mk(1, 'h1000, 1, 'h2000, 1, 0, 0, 1, RR ? 'h1000 : 'h2000, !RR, RR, !RR, 0, 0, 0, 0));
    tbl.push_back(mk(!RR, 'h1000, RR, 'h2000, 1, 0, 0, 1, RR ? 'h2000 : 'h1000, RR, !RR, RR, 0, 0, !RR, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 'h11, 0, 0, 0, 0, 0, RR, !RR, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 'h22, 0, 0, 0, 0, 0, !RR, RR, RR, 0));
    // lock holds inst while data rises
    tbl.push_back(mk(1, 'hbfc00000, 0, 0, 0, 0, 0, 1, 'hbfc00000, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 'hbfc00000, 1, 'h2004, 0, 0, 0, 1, 'hbfc00000, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 'hbfc00000, 1, 'h2004, 0, 0, 0, 1, 'hbfc00000, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 'hbfc00000, 1, 'h2004, 1, 0, 0, 1, 'hbfc00000, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 'h2004, 1, 0, 0, 1, 'h2004, 1, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 'h33, 0, 0, 0, 0, 0, 1, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 'h44, 0, 0, 0, 0, 0, 0, 1, 1, 0));
    // locked requester drops req: one dead cycle, then data issues
    tbl.push_back(mk(1, 'h500, 0, 0, 0, 0, 0, 1, 'h500, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 'h600, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 'h600, 1, 0, 0, 1, 'h600, 1, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 'h55, 0, 0, 0, 0, 0, 0, 1, 1, 0));
    // in-order return steering: inst, data, inst
    tbl.push_back(mk(1, 'h100, 0, 0, 1, 0, 0, 1, 'h100, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 'h200, 1, 0, 0, 1, 'h200, 1, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 'h104, 0, 0, 1, 0, 0, 1, 'h104, 0, 1, 0, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 'hA, 0, 0, 0, 0, 0, 1, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 'hB, 0, 0, 0, 0, 0, 0, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 'hC, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    // fill to OT_DEPTH, then full with simultaneous pop: no bypass
    for (int k = 0; k < 4; k++)
      tbl.push_back(mk(1, 32'h300 + 32'(4 * k), 0, 0, 1, 0, 0, 1, 32'h300 + 32'(4 * k), 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 'h310, 0, 0, 1, 0, 0, 0, 'h310, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 'h310, 0, 0, 1, 1, 'h60, 0, 'h310, 0, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(1, 'h310, 0, 0, 1, 0, 0, 1, 'h310, 0, 1, 0, 0, 0, 0, 0));
    for (int k = 0; k < 4; k++)
      tbl.push_back(mk(0, 0, 0, 0, 0, 1, 32'h61 + 32'(k), 0, 0, 0, 0, 0, 1, 0, 0, 0));
    // m_data_ok with empty FIFO: sticky proto_err
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 'h77, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));

    foreach (tbl[i]) step($sformatf("v%0d", i), tbl[i]);

    do_reset();
    step("clr", idle);

    // reset with two outstanding and a pending lock
    step("mr0", mk(1, 'h700, 0, 0, 1, 0, 0, 1, 'h700, 0, 1, 0, 0, 0, 0, 0));
    step("mr1", mk(0, 0, 1, 'h800, 1, 0, 0, 1, 'h800, 1, 0, 1, 0, 0, 0, 0));
    step("mr2", mk(1, 'h704, 0, 0, 0, 0, 0, 1, 'h704, 0, 0, 0, 0, 0, 1, 0));
    do_reset();
    step("mr3", idle);
    step("mr4", mk(0, 0, 0, 0, 0, 1, 'h99, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    step("mr5", mk(0, 0, 1, 'h900, 1, 0, 0, 1, 'h900, 1, 0, 1, 0, 0, 0, 1));
    step("mr6", mk(0, 0, 0, 0, 0, 1, 'h5a, 0, 0, 0, 0, 0, 0, 1, 1, 1));
    step("mr7", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
